// File: rtl/acc_pkg.sv
// ============================================================================
// acc_pkg : shared encodings for the accumulator-side multiply/divide unit
// Rev 1.0
// ============================================================================
`default_nettype none

package acc_pkg;

  localparam int unsigned DefaultDataWidth = 32;

  localparam logic [1:0] OP_MULU = 2'b00;
  localparam logic [1:0] OP_MULS = 2'b01;
  localparam logic [1:0] OP_DIVU = 2'b10;
  localparam logic [1:0] OP_DIVS = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_CALC = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } mode_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/acc_muldiv_step.sv
// ============================================================================
// acc_muldiv_step : one MUL add-shift or one restoring DIV shift-subtract step
// Rev 1.0
// ============================================================================
`default_nettype none

import acc_pkg::*;

module acc_muldiv_step #(
  parameter int unsigned DataWidth = DefaultDataWidth
) (
  input  mode_e                      mode_i,
  input  logic [2*DataWidth-1:0]     work_i,
  input  logic [DataWidth-1:0]       opnd_i,
  output logic [2*DataWidth-1:0]     work_o
);

  logic [DataWidth-1:0] w_hi;
  logic [DataWidth-1:0] w_lo;
  logic [DataWidth:0]   w_sum;
  logic [DataWidth:0]   w_rs;
  logic                 w_ge;
  logic [DataWidth-1:0] w_rem_sub;

  always_comb begin
    w_hi      = work_i[2*DataWidth-1:DataWidth];
    w_lo      = work_i[DataWidth-1:0];
    w_sum     = {1'b0, w_hi} + (w_lo[0] ? {1'b0, opnd_i} : {(DataWidth+1){1'b0}});
    // remainder shifted left with the next dividend bit; needs W+1 bits before the trial subtract
    w_rs      = {w_hi, w_lo[DataWidth-1]};
    w_ge      = (w_rs >= {1'b0, opnd_i});
    w_rem_sub = w_rs[DataWidth-1:0] - opnd_i;
    work_o    = {w_sum, w_lo[DataWidth-1:1]};
    if (mode_i == MODE_DIV) begin
      if (w_ge) begin
        work_o = {w_rem_sub, w_lo[DataWidth-2:0], 1'b1};
      end else begin
        work_o = {w_rs[DataWidth-1:0], w_lo[DataWidth-2:0], 1'b0};
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/acc_muldiv_seq.sv
// ============================================================================
// acc_muldiv_seq : iterative 32x32 MUL/DIV feeding the accumulator load port
// Rev 1.0
// ============================================================================
`default_nettype none

import acc_pkg::*;

module acc_muldiv_seq #(
  parameter int unsigned DataWidth = DefaultDataWidth
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [1:0]           op_i,
  input  logic [DataWidth-1:0] opa_i,
  input  logic [DataWidth-1:0] opb_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 acc_in_en_o,
  output logic [DataWidth-1:0] result_o,
  output logic [DataWidth-1:0] result_hi_o,
  output logic                 div_zero_o
);

  localparam int unsigned CntW = $clog2(DataWidth + 1);

  state_e                 state_q;
  logic [1:0]             op_q;
  logic [DataWidth-1:0]   opa_q;
  logic [DataWidth-1:0]   opb_q;
  logic [DataWidth-1:0]   opnd_q;
  logic [2*DataWidth-1:0] work_q;
  logic [2*DataWidth-1:0] work_d;
  logic [CntW-1:0]        cnt_q;
  logic                   sign_p_q;
  logic                   sign_q_q;
  logic                   sign_r_q;
  logic                   busy_q;
  logic                   done_q;
  logic [DataWidth-1:0]   res_q;
  logic [DataWidth-1:0]   res_hi_q;
  logic                   dz_q;

  logic                   w_is_div;
  logic                   w_a_neg;
  logic                   w_b_neg;
  logic [DataWidth-1:0]   w_a_abs;
  logic [DataWidth-1:0]   w_b_abs;
  logic [2*DataWidth-1:0] w_prod;
  logic [DataWidth-1:0]   w_quo;
  logic [DataWidth-1:0]   w_rem;
  mode_e                  w_mode;

  always_comb begin
    w_is_div = op_is_div(op_q);
    w_mode   = w_is_div ? MODE_DIV : MODE_MUL;
    w_a_neg  = op_is_signed(op_q) & opa_q[DataWidth-1];
    w_b_neg  = op_is_signed(op_q) & opb_q[DataWidth-1];
    w_a_abs  = w_a_neg ? -opa_q : opa_q;
    w_b_abs  = w_b_neg ? -opb_q : opb_q;
    w_prod   = sign_p_q ? -work_q : work_q;
    w_quo    = sign_q_q ? -work_q[DataWidth-1:0] : work_q[DataWidth-1:0];
    w_rem    = sign_r_q ? -work_q[2*DataWidth-1:DataWidth] : work_q[2*DataWidth-1:DataWidth];
  end

  acc_muldiv_step #(
    .DataWidth (DataWidth)
  ) u_step (
    .mode_i (w_mode),
    .work_i (work_q),
    .opnd_i (opnd_q),
    .work_o (work_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= 2'b00;
      opa_q    <= '0;
      opb_q    <= '0;
      opnd_q   <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      sign_p_q <= 1'b0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      res_q    <= '0;
      res_hi_q <= '0;
      dz_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            op_q    <= op_i;
            opa_q   <= opa_i;
            opb_q   <= opb_i;
            busy_q  <= 1'b1;
            dz_q    <= 1'b0;
            state_q <= ST_PREP;
          end
        end
        ST_PREP: begin
          // Low half of work holds the multiplier (MUL) or dividend (DIV); high half starts clear
          if (w_is_div) begin
            work_q <= {{DataWidth{1'b0}}, w_a_abs};
            opnd_q <= w_b_abs;
          end else begin
            work_q <= {{DataWidth{1'b0}}, w_b_abs};
            opnd_q <= w_a_abs;
          end
          sign_p_q <= ~w_is_div & (w_a_neg ^ w_b_neg);
          sign_q_q <= w_is_div & (w_a_neg ^ w_b_neg);
          sign_r_q <= w_is_div & w_a_neg;
          cnt_q    <= CntW'(DataWidth);
          state_q  <= ST_CALC;
        end
        ST_CALC: begin
          if (cnt_q == '0) begin
            state_q <= ST_FIX;
          end else begin
            work_q <= work_d;
            cnt_q  <= cnt_q - 1'b1;
          end
        end
        ST_FIX: begin
          if (!w_is_div) begin
            res_q    <= w_prod[DataWidth-1:0];
            res_hi_q <= w_prod[2*DataWidth-1:DataWidth];
          end else if (opb_q == '0) begin
            res_q    <= {DataWidth{1'b1}};
            res_hi_q <= opa_q;
            dz_q     <= 1'b1;
          end else begin
            res_q    <= w_quo;
            res_hi_q <= w_rem;
          end
          done_q  <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign acc_in_en_o = done_q;
  assign result_o    = res_q;
  assign result_hi_o = res_hi_q;
  assign div_zero_o  = dz_q;

endmodule

`default_nettype wire

// File: tb/tb_acc_muldiv_seq.sv
// ============================================================================
// tb_acc_muldiv_seq : directed scoreboard bench for acc_muldiv_seq
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_acc_muldiv_seq;
  import acc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] opa_i = '0;
  logic [31:0] opb_i = '0;
  logic        busy_o;
  logic        done_o;
  logic        acc_in_en_o;
  logic [31:0] result_o;
  logic [31:0] result_hi_o;
  logic        div_zero_o;

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic        dz;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;

  acc_muldiv_seq #(.DataWidth(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .op_i        (op_i),
    .opa_i       (opa_i),
    .opb_i       (opb_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .acc_in_en_o (acc_in_en_o),
    .result_o    (result_o),
    .result_hi_o (result_hi_o),
    .div_zero_o  (div_zero_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse consumes one scoreboard entry
  always @(negedge clk) begin
    if (rst_n && done_o === 1'b1) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got result 0x%08h with empty scoreboard", result_o);
      end else begin
        e = sb.pop_front();
        check({e.name, "_res"}, result_o, e.res);
        check({e.name, "_hi"}, result_hi_o, e.hi);
        check({e.name, "_dz"}, {31'b0, div_zero_o}, {31'b0, e.dz});
        check({e.name, "_acc_en"}, {31'b0, acc_in_en_o}, 32'd1);
      end
    end
  end

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input logic [31:0] eh,
                        input logic edz, input bit intrude);
    exp_t e;
    int   n;
    int   d0;
    @(negedge clk);
    start_i = 1'b1;
    op_i    = op;
    opa_i   = a;
    opb_i   = b;
    e.res = er; e.hi = eh; e.dz = edz; e.name = name;
    sb.push_back(e);
    d0 = done_cnt;
    @(posedge clk); #1;
    start_i = 1'b0;
    op_i    = ~op;
    opa_i   = 32'hDEAD_BEEF;
    opb_i   = 32'h0BAD_F00D;
    check({name, "_busy_start"}, {31'b0, busy_o}, 32'd1);
    check({name, "_dz_cleared"}, {31'b0, div_zero_o}, 32'd0);
    n = 0;
    while (done_o !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (intrude && n == 10) begin
        start_i = 1'b1;
        op_i    = OP_MULU;
        opa_i   = 32'd2;
        opb_i   = 32'd3;
      end else begin
        start_i = 1'b0;
      end
    end
    check({name, "_latency"}, n, 32'd35);
    @(posedge clk); #1;
    check({name, "_busy_end"}, {31'b0, busy_o}, 32'd0);
    check({name, "_done_pulse"}, {31'b0, done_o}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check({name, "_done_count"}, done_cnt - d0, 32'd1);
    check({name, "_hold"}, result_o, er);
  endtask

  initial begin
    int d0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'b0, busy_o}, 32'd0);
    check("reset_done", {31'b0, done_o}, 32'd0);
    check("reset_result", result_o, 32'd0);
    check("reset_hi", result_hi_o, 32'd0);
    check("reset_dz", {31'b0, div_zero_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mulu_7x6",     OP_MULU, 32'd7,        32'd6,        32'h0000002A, 32'h00000000, 1'b0, 1'b0);
    run_op("muls_m3x5",    OP_MULS, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 32'hFFFFFFFF, 1'b0, 1'b0);
    run_op("mulu_big3x5",  OP_MULU, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 32'h00000004, 1'b0, 1'b0);
    run_op("divs_m7d2",    OP_DIVS, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0);
    run_op("divu_dz",      OP_DIVU, 32'h00001234, 32'd0,        32'hFFFFFFFF, 32'h00001234, 1'b1, 1'b0);
    run_op("divu_100d7",   OP_DIVU, 32'd100,      32'd7,        32'h0000000E, 32'h00000002, 1'b0, 1'b0);
    run_op("divs_min_m1",  OP_DIVS, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 1'b0);
    run_op("divs_7dm2",    OP_DIVS, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 1'b0, 1'b0);
    run_op("divs_dz",      OP_DIVS, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 1'b0);
    run_op("muls_m1xm1",   OP_MULS, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0);
    run_op("mulu_max",     OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0);
    run_op("muls_minmin",  OP_MULS, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 1'b0, 1'b0);
    run_op("mulu_intrude", OP_MULU, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, 1'b0, 1'b1);

    // Abort mid-CALC with an asynchronous reset
    @(negedge clk);
    start_i = 1'b1;
    op_i    = OP_MULU;
    opa_i   = 32'h12345678;
    opb_i   = 32'd9;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy_o}, 32'd0);
    check("abort_done", {31'b0, done_o}, 32'd0);
    check("abort_acc_en", {31'b0, acc_in_en_o}, 32'd0);
    check("abort_result", result_o, 32'd0);
    check("abort_hi", result_hi_o, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - d0, 32'd0);
    check("abort_idle_result", result_o, 32'd0);

    run_op("divu_after_rst", OP_DIVU, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 32'h0000000F, 1'b0, 1'b0);

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
